// File: rtl/keypad_scan_encoder_if.sv
// Keypad pin and report handshake bundle for keypad_scan_encoder.
// slave: the encoder side; master: keypad pins plus the report consumer.
interface keypad_scan_encoder_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       valid;
  logic       ready;
  logic       multi;
  logic       ovr;

  modport slave  (input col, ready, output row, key, valid, multi, ovr);
  modport master (output col, ready, input row, key, valid, multi, ovr);
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with per-scan debounce and a VALID/READY report port.
// A report is {row, col} of the first closed key; MULTI flags more than one closed key.
module keypad_scan_encoder #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  keypad_scan_encoder_if.slave kif
);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, COUNT, PRESSED} state_t;

  logic [1:0]    r;
  logic [DW-1:0] d;
  logic          sample, scan_end;

  assign sample   = (d == DW'(DWELL - 1));
  assign scan_end = sample && (r == 2'd3);
  assign kif.row  = ~(4'b0001 << r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      d <= '0;
    end else if (sample) begin
      d <= '0;
      r <= r + 2'd1;
    end else begin
      d <= d + DW'(1);
    end
  end

  // Fold the currently driven row into the running scan result.
  logic [3:0] closed;
  logic [1:0] first_col;
  logic [2:0] row_cnt, hit_sum;
  logic       acc_found, res_found, res_multi;
  logic [3:0] acc_code, res_code;
  logic [1:0] acc_hits, res_hits;

  always_comb begin
    closed    = ~kif.col;
    first_col = '0;
    row_cnt   = '0;
    for (int i = 3; i >= 0; i--)
      if (closed[i]) first_col = 2'(i);
    for (int i = 0; i < 4; i++)
      row_cnt = row_cnt + 3'(closed[i]);
    res_found = acc_found | (|closed);
    res_code  = acc_found ? acc_code : {r, first_col};
    hit_sum   = 3'(acc_hits) + row_cnt;
    res_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    res_multi = res_hits[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_found <= 1'b0;
      acc_code  <= '0;
      acc_hits  <= '0;
    end else if (scan_end) begin
      acc_found <= 1'b0;
      acc_code  <= '0;
      acc_hits  <= '0;
    end else if (sample) begin
      acc_found <= res_found;
      acc_code  <= res_code;
      acc_hits  <= res_hits;
    end
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, rel, rel_n;
  logic [3:0]    held, held_n;
  logic          held_multi, held_multi_n;
  logic          issue, issue_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rel        <= '0;
      held       <= '0;
      held_multi <= 1'b0;
      issue      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rel        <= rel_n;
      held       <= held_n;
      held_multi <= held_multi_n;
      issue      <= issue_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    rel_n        = rel;
    held_n       = held;
    held_multi_n = held_multi;
    issue_n      = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: if (res_found) begin
          held_n       = res_code;
          held_multi_n = res_multi;
          cnt_n        = CW'(1);
          state_n      = COUNT;
          if (DEBOUNCE == 1) begin
            issue_n = 1'b1;
            state_n = PRESSED;
            rel_n   = '0;
          end
        end
        COUNT: begin
          if (!res_found) begin
            state_n = IDLE;
          end else if (res_code != held) begin
            held_n       = res_code;
            held_multi_n = res_multi;
            cnt_n        = CW'(1);
          end else begin
            held_multi_n = res_multi;
            cnt_n        = cnt + CW'(1);
            if (cnt_n == CW'(DEBOUNCE)) begin
              issue_n = 1'b1;
              state_n = PRESSED;
              rel_n   = '0;
            end
          end
        end
        PRESSED: begin
          // Any key, including a different one, just restarts release counting.
          if (res_found) begin
            rel_n = '0;
          end else begin
            rel_n = rel + CW'(1);
            if (rel_n == CW'(DEBOUNCE)) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [3:0] key_q;
  logic       valid_q, multi_q, ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (issue) begin
      // A consumer accepting in this same cycle frees the slot for the new report.
      if (!valid_q || kif.ready) begin
        key_q   <= held;
        multi_q <= held_multi;
        valid_q <= 1'b1;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && kif.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign kif.key   = key_q;
  assign kif.valid = valid_q;
  assign kif.multi = multi_q;
  assign kif.ovr   = ovr_q;
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder: scan-level reference model plus directed
// and randomized key sequences.
module tb_keypad_scan_encoder;
  localparam int DWELL = 4;
  localparam int DEB   = 3;
  localparam int SCAN  = 4 * DWELL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_encoder_if kif();
  keypad_scan_encoder #(.DWELL(DWELL), .DEBOUNCE(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  // Physical keypad: bit row*4+col closed pulls that column low while its row is driven.
  logic [15:0] pressed = '0;
  always_comb begin
    kif.col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kif.row[r]) kif.col = kif.col & ~pressed[r*4 +: 4];
  end

  int npass = 0;
  int ntot  = 0;

  // Reference model state
  int         pos;
  int         m_st, m_cnt, m_rel;
  logic [3:0] m_held, m_key;
  logic       m_hmulti, m_valid, m_multi, m_ovr, m_issue;

  task automatic model_reset();
    pos = 0; m_st = 0; m_cnt = 0; m_rel = 0;
    m_held = '0; m_key = '0; m_hmulti = 0;
    m_valid = 0; m_multi = 0; m_ovr = 0; m_issue = 0;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int n, first;
    logic [3:0] c;
    logic mu;
    n = 0; first = -1;
    for (int i = 0; i < 16; i++)
      if (k[i]) begin
        n++;
        if (first < 0) first = i;
      end
    if (first < 0) begin
      if (m_st == 1) m_st = 0;
      else if (m_st == 2) begin
        m_rel++;
        if (m_rel == DEB) m_st = 0;
      end
    end else begin
      c = 4'(first);
      mu = (n > 1);
      if (m_st == 0) begin
        m_held = c; m_hmulti = mu; m_cnt = 1; m_st = 1;
      end else if (m_st == 1) begin
        if (c == m_held) begin m_cnt++; m_hmulti = mu; end
        else begin m_held = c; m_hmulti = mu; m_cnt = 1; end
      end else begin
        m_rel = 0;
      end
      if (m_st == 1 && m_cnt == DEB) begin
        m_issue = 1; m_st = 2; m_rel = 0;
      end
    end
  endtask

  // Advance one clock and replay the edge that just happened in the model.
  task automatic cycle();
    @(negedge clk);
    if (m_issue) begin
      if (!m_valid || kif.ready) begin
        m_key = m_held; m_multi = m_hmulti; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      m_issue = 0;
    end else if (m_valid && kif.ready) begin
      m_valid = 0;
    end
    if (pos == SCAN - 1) model_scan(pressed);
    pos = (pos + 1) % SCAN;
  endtask

  function automatic logic [6:0] mexp();
    return {m_valid, m_key, m_multi, m_ovr};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pressed = '0; kif.ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [3:0] er;
    kif.ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2 * DWELL) cycle();
    #2 rst = 1'b1;
    #1;
    ntot++;
    if ({kif.row, kif.valid, kif.ovr, kif.key, kif.multi} !== 11'b1110_0_0_0000_0)
      $display("FAIL reset_async: got row=%b v=%b o=%b k=%b m=%b want row=1110 all zero",
               kif.row, kif.valid, kif.ovr, kif.key, kif.multi);
    else npass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < SCAN; k++) begin
      er = ~(4'b0001 << (k / DWELL));
      ntot++;
      if (kif.row !== er) $display("FAIL reset_rowseq k%0d: got %b want %b", k, kif.row, er);
      else npass++;
      cycle();
    end
  endtask

  task automatic test_single();
    do_reset();
    pressed = 16'h0200;  // row 2 col 1
    for (int s = 0; s < 6; s++)
      for (int j = 0; j < SCAN; j++) begin
        kif.ready = (s == 3 && j == 4);
        cycle();
        ntot++;
        if ({kif.valid, kif.key, kif.multi, kif.ovr} !== mexp())
          $display("FAIL single s%0d c%0d: got %b want %b", s, j,
                   {kif.valid, kif.key, kif.multi, kif.ovr}, mexp());
        else npass++;
        if (s == 3 && j == 0) begin
          ntot++;
          if ({kif.valid, kif.key, kif.multi} !== 6'b1_1001_0)
            $display("FAIL single_report: got %b want 110010", {kif.valid, kif.key, kif.multi});
          else npass++;
        end
        if (s == 3 && j == 5) begin
          ntot++;
          if (kif.valid !== 1'b0) $display("FAIL single_accept: got valid=%b want 0", kif.valid);
          else npass++;
        end
      end
    kif.ready = 1'b0;
  endtask

  task automatic test_bounce();
    logic [15:0] seq [$] = '{16'h4000, 16'h4000, 16'h0, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                             16'h0, 16'h0, 16'h0, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    int rises;
    logic pv;
    do_reset();
    rises = 0; pv = 1'b0;
    for (int s = 0; s < seq.size(); s++) begin
      pressed = seq[s];
      for (int j = 0; j < SCAN; j++) begin
        kif.ready = (s == 7 && j == 2);
        cycle();
        if (kif.valid === 1'b1 && pv !== 1'b1) rises++;
        pv = kif.valid;
        ntot++;
        if ({kif.valid, kif.key, kif.multi, kif.ovr} !== mexp())
          $display("FAIL bounce s%0d c%0d: got %b want %b", s, j,
                   {kif.valid, kif.key, kif.multi, kif.ovr}, mexp());
        else npass++;
        if ((s == 5 && j == SCAN - 1) || (s == 6 && j == 0)) begin
          ntot++;
          if (kif.valid !== (s == 6)) $display("FAIL bounce_latency s%0d: got valid=%b", s, kif.valid);
          else npass++;
        end
      end
    end
    kif.ready = 1'b0;
    ntot++;
    if (rises !== 2) $display("FAIL bounce_reports: got %0d want 2", rises);
    else npass++;
  endtask

  task automatic test_multi();
    do_reset();
    pressed = 16'h0018;  // row0 col3 and row1 col0
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < SCAN; j++) begin
        cycle();
        ntot++;
        if ({kif.valid, kif.key, kif.multi, kif.ovr} !== mexp())
          $display("FAIL multi s%0d c%0d: got %b want %b", s, j,
                   {kif.valid, kif.key, kif.multi, kif.ovr}, mexp());
        else npass++;
        if (s == 3 && j == 0) begin
          ntot++;
          if ({kif.valid, kif.key, kif.multi} !== 6'b1_0011_1)
            $display("FAIL multi_report: got %b want 100111", {kif.valid, kif.key, kif.multi});
          else npass++;
        end
      end
  endtask

  task automatic test_overrun();
    logic [15:0] seq [$] = '{16'h0020, 16'h0020, 16'h0020, 16'h0, 16'h0, 16'h0,
                             16'h0400, 16'h0400, 16'h0400, 16'h0, 16'h0, 16'h0};
    do_reset();
    for (int s = 0; s < seq.size(); s++) begin
      pressed = seq[s];
      for (int j = 0; j < SCAN; j++) begin
        kif.ready = (s == 10 && j == 0);
        cycle();
        ntot++;
        if ({kif.valid, kif.key, kif.multi, kif.ovr} !== mexp())
          $display("FAIL overrun s%0d c%0d: got %b want %b", s, j,
                   {kif.valid, kif.key, kif.multi, kif.ovr}, mexp());
        else npass++;
        if (s == 9 && j == 1) begin
          ntot++;
          if ({kif.valid, kif.key, kif.ovr} !== 6'b1_0101_1)
            $display("FAIL overrun_drop: got %b want 101011", {kif.valid, kif.key, kif.ovr});
          else npass++;
        end
      end
    end
    kif.ready = 1'b0;
    ntot++;
    if ({kif.valid, kif.ovr} !== 2'b01)
      $display("FAIL overrun_sticky: got v=%b o=%b want v=0 o=1", kif.valid, kif.ovr);
    else npass++;
    do_reset();
    ntot++;
    if (kif.ovr !== 1'b0) $display("FAIL overrun_clear: got %b want 0", kif.ovr);
    else npass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [$] = '{16'h0040, 16'h0040, 16'h0040, 16'h0, 16'h0, 16'h0,
                             16'h1000, 16'h1000, 16'h1000, 16'h1000};
    do_reset();
    for (int s = 0; s < seq.size(); s++) begin
      pressed = seq[s];
      for (int j = 0; j < SCAN; j++) begin
        kif.ready = (s == 9 && j == 0);
        cycle();
        ntot++;
        if ({kif.valid, kif.key, kif.multi, kif.ovr} !== mexp())
          $display("FAIL b2b s%0d c%0d: got %b want %b", s, j,
                   {kif.valid, kif.key, kif.multi, kif.ovr}, mexp());
        else npass++;
        if (s == 9 && j == 0) begin
          ntot++;
          if ({kif.valid, kif.key, kif.ovr} !== 6'b1_1100_0)
            $display("FAIL b2b_replace: got %b want 111000", {kif.valid, kif.key, kif.ovr});
          else npass++;
        end
      end
    end
    kif.ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] k;
    int hold;
    do_reset();
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 3))
        0, 1: k = '0;
        2:    k = 16'(1) << $urandom_range(0, 15);
        default: k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      hold = $urandom_range(1, 5);
      pressed = k;
      for (int s = 0; s < hold; s++)
        for (int j = 0; j < SCAN; j++) begin
          kif.ready = ($urandom_range(0, 3) == 0);
          cycle();
          ntot++;
          if ({kif.valid, kif.key, kif.multi, kif.ovr} !== mexp())
            $display("FAIL random seg%0d s%0d c%0d: got %b want %b", seg, s, j,
                     {kif.valid, kif.key, kif.multi, kif.ovr}, mexp());
          else npass++;
        end
    end
    kif.ready = 1'b0;
  endtask

  initial begin
    kif.ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_bounce();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Sequential encoder for a 4x4 active-low key matrix.
- Drives the same active-low one-hot row pattern the team's 2-to-4 decoder produces (1110, 1101, 1011, 0111), senses the columns and debounces the result.
- Emits a 4-bit key code to a consumer through a VALID/READY handshake.
- Sits between the keypad pins and the control logic.

Parameters:
- DWELL, 4, clock cycles each row is driven per scan; legal range 2 or more; column sample on last dwell cycle.
- DEBOUNCE, 3, consecutive identical full-scan results required to accept a press, and consecutive empty scans required to accept a release; legal range 1 or more.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- COL  in  4  column sense, active-low; COL[i]=0 means a key in column i of the driven row is closed.
- ROW  out 4  row drive, active-low one-hot.
- KEY  out 4  reported code {row[1:0], col[1:0]}.
- VALID out 1  KEY holds a report not yet accepted.
- READY in  1  consumer accepts when VALID and READY are both high at a rising edge.
- MULTI out 1  more than one closed key in the reported scan; qualified by VALID.
- OVR  out 1  sticky; set when a report is dropped because VALID is still high; cleared only by RST.

Behaviour:
- Reset is asynchronous and active-high. While RST is asserted:
  - row index r=0, dwell counter d=0, ROW=4'b1110.
  - KEY=0, VALID=0, MULTI=0, OVR=0.
  - debounce counters=0, FSM=IDLE.
  - Reset mid-scan or mid-handshake discards all partial state.
- Scan timing:
  - ROW = ~(4'b0001 << r).
  - d counts 0..DWELL-1. COL is sampled when d==DWELL-1, then r advances and wraps from 3 to 0.
  - One full scan is 4*DWELL cycles; the default is 16.
- Per-scan accumulation:
  - The candidate is the first closed key found: lowest row first, then lowest column index within that row.
  - The hit count saturates at 2 and gives the multi flag.
  - The scan result is resolved at the row-3 sample. It is either "none" or a code plus the multi flag.
- FSM (updates only at scan end):
  - IDLE:
    - result none -> stay.
    - result c -> COUNT with held=c, cnt=1.
    - If DEBOUNCE==1, report immediately and go to PRESSED.
  - COUNT:
    - same c -> cnt+1. When cnt reaches DEBOUNCE, issue a report and go to PRESSED.
    - a different code -> held=new code, cnt=1.
    - none -> IDLE.
  - PRESSED:
    - none -> release counter+1. When it reaches DEBOUNCE -> IDLE.
    - any key -> release counter=0.
    - A different key while in PRESSED is ignored (no rollover).
- Report issue, in the cycle after the final debounce scan end:
  - If VALID=0, or VALID=1 with READY=1 in that same cycle: load KEY=held and MULTI, set VALID=1.
  - Otherwise drop the report, leave KEY, MULTI and VALID unchanged, and set OVR=1.
- Handshake:
  - KEY and MULTI are stable while VALID=1.
  - When VALID&READY are high at an edge with no simultaneous report, VALID goes low on the next cycle.
  - READY while VALID=0 has no effect.
- Latency: from a clean press present from a scan start, VALID rises one cycle after the DEBOUNCE-th scan end. The default is 3 scans, 48 cycles, plus 1.
- Only one report is issued per press-release cycle.

Test Plan:
- Reset: assert RST mid-scan at r=2 -> ROW=1110, VALID=0, OVR=0 asynchronously. After release, ROW steps 1110, 1101, 1011, 0111, each for 4 cycles.
- Single key, row 2 col 1: COL=1101 whenever ROW=1011, READY=0.
  - After 3 scans: VALID=1, KEY=4'b1001, MULTI=0, held stable.
  - READY pulse -> VALID=0 next cycle.
  - Key still held -> no second report.
- Bounce: key present 2 scans, absent 1, present 3 -> exactly one report, after the 6th scan. Release 3 empty scans -> FSM IDLE.
- Multi-key: row 0 col 3 and row 1 col 0 closed -> KEY=4'b0011, MULTI=1.
- Overrun:
  - READY held 0; press and release key 0x5, then press and release key 0xA.
  - Second report dropped, OVR=1, KEY stays 4'b0101.
  - OVR persists after READY until RST.
- Back-to-back: arrange VALID=1 with READY=1 in the same cycle a new debounced report issues -> VALID stays 1, KEY updates to the new code, OVR stays 0.
